// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state encoding and width helper for the APB master bridge
package apb_bridge_pkg;
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    RESP   = 4'b1000
  } state_t;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: slave-index field of the address to one-hot select plus out-of-range flag
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               dec_err
);
  localparam int IW = clog2(NUM_SLV);
  logic [IW-1:0] idx;
  logic          unused_addr;
  assign idx         = addr[SEL_LSB +: IW];
  assign unused_addr = ^addr;
  assign dec_err     = int'(idx) >= NUM_SLV;
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
    assign sel[i] = int'(idx) == i;
  end
endmodule

// File: rtl/apb_multi_master.sv
// apb_multi_master: valid/ready request port to APB3/APB4 transfers with decoded PSEL and wait-state timeout
module apb_multi_master
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [NUM_SLV-1:0]  PSEL,
  output logic                PENABLE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);
  localparam int SW = DATA_W / 8;
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d, sel;
  logic                penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [SW-1:0]       pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dec_err, timeout;
  apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB)) u_dec (
    .addr(req_addr),
    .sel(sel),
    .dec_err(dec_err)
  );
  assign timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (dec_err) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d  = SETUP;
          psel_d   = sel;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (PREADY || timeout) begin
        state_d     = RESP;
        psel_d      = '0;
        penable_d   = 1'b0;
        pstrb_d     = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !PREADY || PSLVERR;
        rsp_rdata_d = (PREADY && !PSLVERR && !pwrite_q) ? PRDATA : '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
endmodule

// File: doc/apb_multi_master.md
# apb_multi_master

Parametrised APB master bridge: converts a simple valid/ready request port into APB3/APB4 transfers for up to NUM_SLV slaves, with address-decoded PSEL, byte strobes, slave-error reporting and a wait-state timeout. Sits between the UART/GPIO command logic and the shared APB slave bus. It generalises the single-select IDLE/SETUP/ENABLE bridge: one request in flight, fully registered outputs, an explicit response pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; multiple of 8
- NUM_SLV, 4, number of PSEL lines, 1..16
- SEL_LSB, 28, lowest PADDR bit of the slave-index field; field width = clog2(NUM_SLV), minimum 1
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout

- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 on writes and errors
- rsp_err  out  1  PSLVERR, decode error or timeout
- PSEL  out  NUM_SLV  one-hot slave select
- PENABLE  out  1  access phase
- PADDR  out  ADDR_W  address
- PWRITE  out  1  direction
- PWDATA  out  DATA_W  write data
- PSTRB  out  DATA_W/8  strobes; forced to 0 on reads
- PRDATA  in  DATA_W  muxed read data from the interconnect
- PREADY  in  1  muxed ready
- PSLVERR  in  1  muxed error; sampled only with PREADY

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch the request, decode idx = req_addr[SEL_LSB +: clog2(NUM_SLV)], and go to SETUP. If idx >= NUM_SLV, go directly to RESP with rsp_err=1, rsp_rdata=0, and assert no PSEL.
- SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid. Always go to ACCESS next.
- ACCESS: PENABLE=1; all address/control outputs held stable. On PREADY=1: capture PRDATA (reads only) and PSLVERR into rsp_err, drop PSEL/PENABLE, go to RESP.
- Timeout: wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When TIMEOUT≠0 and count reaches TIMEOUT: abort the transfer (PSEL/PENABLE drop), set rsp_err=1, set rsp_rdata=0, go to RESP. If PREADY=1 arrives in the same cycle, the normal completion wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The response has no back-pressure.
- req_ready is 0 in SETUP, ACCESS and RESP. Request inputs are ignored outside IDLE.
- Idle bus: PSEL=0, PENABLE=0. PADDR/PWDATA hold their last values; PSTRB=0.

## Timing
- Reset (asynchronous, any state): state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready=1 from the first clock after release.
- Reset mid-transfer aborts the transfer immediately; no response is produced.
- All outputs are registered. req_ready is decoded from the state register.
- Accept edge at cycle N: SETUP during N+1, ACCESS from N+2. PREADY high in ACCESS cycle N+2+w gives rsp_valid in cycle N+3+w.
- Zero-wait transfer: 4 cycles accept-to-accept.
- Decode error: rsp_valid one cycle after accept; the APB bus is untouched.

## Structure
- Package apb_bridge_pkg: state encoding localparams (IDLE/SETUP/ACCESS/RESP, one-hot 4-bit) and a clog2 function.
- Sub-module apb_addr_decode (combinational): addr → one-hot sel[NUM_SLV] plus a dec_err flag. It is instantiated once and registered into PSEL in SETUP.
- The timeout counter stays inline. Its width is clog2(TIMEOUT+1).

## Test plan
- Write req_addr=0x1000_0010, req_wdata=0xA5A5_5A5A, req_strb=0xF, PREADY always 1 → PSEL=4'b0010 for 2 cycles, PENABLE 1 cycle, PSTRB=0xF. rsp_valid 3 cycles after accept with rsp_err=0.
- Read addr=0x2000_0004, PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF on the ready cycle → PADDR/PSEL stable throughout; rsp_rdata=0xDEAD_BEEF 6 cycles after accept; PSTRB=0.
- Write with PSLVERR=1 on the ready cycle → rsp_err=1; the next request is accepted the cycle after rsp_valid.
- NUM_SLV=3, addr=0x3000_0000 → no PSEL ever asserted; rsp_valid plus rsp_err=1 one cycle after accept.
- TIMEOUT=16, PREADY held 0 → abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on cycle 16 → normal completion, rsp_err=0.
- PRESETn pulsed low during ACCESS → all outputs 0 asynchronously, no rsp_valid; a fresh request after reset completes normally.
